// File: rtl/card_dealer.sv
// Purpose  : captures a shuffled deck streamed by the shuffler, checks it, then deals cards in arrival order.
// Latency  : card captured one edge after each shuffler update; a deal is registered on the edge sampling dealReq.
// Backpress: no stalls; dealReq is ignored unless READY, and newDeck beats dealReq in the same cycle.
// Ports    : clk/rst (async, active-low); loadFlag/card = shuffler stream in; shuffleFlag = shuffle request out;
//            newDeck/dealReq = controller requests; dealValid/dealCard = deal strobe and card;
//            cardsLeft/deckReady/deckEmpty/loadErr = deck status.
module card_dealer #(
  parameter int DECK_SIZE   = 52,
  parameter int CARD_W      = 6,
  parameter int LOAD_PERIOD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadFlag,
  input  logic [CARD_W-1:0] card,
  output logic              shuffleFlag,
  input  logic              newDeck,
  input  logic              dealReq,
  output logic              dealValid,
  output logic [CARD_W-1:0] dealCard,
  output logic [5:0]        cardsLeft,
  output logic              deckReady,
  output logic              deckEmpty,
  output logic              loadErr
);

  localparam int IDX_W = $clog2(DECK_SIZE);
  localparam int PH_W  = $clog2(LOAD_PERIOD + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_SIZE - 1);

  typedef enum logic [1:0] {WAIT_LOAD, LOADING, READY, EMPTY} state_t;

  state_t               state, state_nxt;
  logic                 loadPrev;
  logic [IDX_W-1:0]     wrIdx, rdIdx;
  logic [PH_W-1:0]      phase;
  logic [DECK_SIZE-1:0] seen;
  logic [CARD_W-1:0]    deck [DECK_SIZE];

  logic load_start, capture, abort, load_done, deal, flush, card_bad;

  // Out-of-range codes are flagged before the seen-mask lookup so the
  // mask is never indexed past its end.
  always_comb begin
    card_bad = 1'b1;
    if (int'(card) < DECK_SIZE)
      card_bad = seen[card[IDX_W-1:0]];
  end

  always_comb begin
    state_nxt  = state;
    load_start = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    load_done  = 1'b0;
    deal       = 1'b0;
    flush      = 1'b0;
    case (state)
      WAIT_LOAD: begin
        // Only a fresh rising edge starts a load; a level left high is ignored.
        if (loadFlag && !loadPrev) begin
          load_start = 1'b1;
          state_nxt  = LOADING;
        end
      end
      LOADING: begin
        if (!loadFlag) begin
          abort     = 1'b1;
          state_nxt = WAIT_LOAD;
        end else if (phase == '0) begin
          capture = 1'b1;
          if (wrIdx == LAST_IDX) begin
            load_done = 1'b1;
            state_nxt = READY;
          end
        end
      end
      READY: begin
        if (newDeck) begin
          flush     = 1'b1;
          state_nxt = WAIT_LOAD;
        end else if (dealReq) begin
          deal = 1'b1;
          if (cardsLeft == 6'd1)
            state_nxt = EMPTY;
        end
      end
      EMPTY: begin
        if (newDeck) begin
          flush     = 1'b1;
          state_nxt = WAIT_LOAD;
        end
      end
      default: state_nxt = WAIT_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= WAIT_LOAD;
      loadPrev    <= 1'b0;
      shuffleFlag <= 1'b0;
      wrIdx       <= '0;
      rdIdx       <= '0;
      phase       <= '0;
      seen        <= '0;
      dealValid   <= 1'b0;
      dealCard    <= '0;
      cardsLeft   <= '0;
      deckReady   <= 1'b0;
      deckEmpty   <= 1'b0;
      loadErr     <= 1'b0;
    end else begin
      state       <= state_nxt;
      loadPrev    <= loadFlag;
      // Request a shuffle whenever we are (or are about to be) waiting for a load.
      shuffleFlag <= (state_nxt == WAIT_LOAD);
      dealValid   <= deal;

      if (load_start) begin
        wrIdx <= '0;
        seen  <= '0;
        phase <= '0;
      end

      // phase==0 marks a capture edge; reload so the next capture lands P edges later.
      if (capture) begin
        wrIdx <= wrIdx + 1'b1;
        phase <= PH_W'(LOAD_PERIOD - 1);
        if (card_bad)
          loadErr <= 1'b1;
        if (int'(card) < DECK_SIZE)
          seen[card[IDX_W-1:0]] <= 1'b1;
      end else if (state == LOADING && phase != '0) begin
        phase <= phase - 1'b1;
      end

      if (load_done) begin
        cardsLeft <= 6'(DECK_SIZE);
        rdIdx     <= '0;
        deckReady <= 1'b1;
      end

      if (abort)
        loadErr <= 1'b1;

      if (deal) begin
        dealCard  <= deck[rdIdx];
        rdIdx     <= rdIdx + 1'b1;
        cardsLeft <= cardsLeft - 6'd1;
        if (cardsLeft == 6'd1) begin
          deckReady <= 1'b0;
          deckEmpty <= 1'b1;
        end
      end

      if (flush) begin
        deckReady <= 1'b0;
        deckEmpty <= 1'b0;
        cardsLeft <= '0;
        loadErr   <= 1'b0;
      end
    end
  end

  // Deck storage carries no reset: contents are only read after a full load.
  always_ff @(posedge clk) begin
    if (capture)
      deck[wrIdx] <= card;
  end

endmodule

// File: doc/card_dealer.md
# card_dealer

Receiving end of the shuffler's card-load stream, and the deal port for the game controller. Requests a shuffle and captures the 52 cards streamed on `loadFlag`/`card` into a local deck buffer, checking each for range and duplicates. It then hands out cards one per request, first-received first, until the deck is exhausted or a new deck is requested.

## Interface
- `DECK_SIZE`, 52, cards per deck; number of captures per load.
- `CARD_W`, 6, card code width.
- `LOAD_PERIOD`, 2, clock cycles between successive `card` updates from the shuffler.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `loadFlag`  in  1  shuffler load-in-progress level; stays high after the last card.
- `card`  in  CARD_W  card code from the shuffler; new value every LOAD_PERIOD cycles.
- `shuffleFlag`  out  1  shuffle request to the shuffler.
- `newDeck`  in  1  single-cycle pulse: discard current deck and load a new one.
- `dealReq`  in  1  single-cycle deal request.
- `dealValid`  out  1  one-cycle strobe: `dealCard` is valid.
- `dealCard`  out  CARD_W  dealt card code.
- `cardsLeft`  out  6  undealt cards in buffer (0..DECK_SIZE).
- `deckReady`  out  1  deck fully loaded; deals accepted.
- `deckEmpty`  out  1  loaded deck fully dealt.
- `loadErr`  out  1  sticky load error.

## Operation
- States: WAIT_LOAD, LOADING, READY, EMPTY. Reset enters WAIT_LOAD.
- `loadFlag` is registered once (`loadPrev`). A rising edge is detected when `loadFlag`=1 and `loadPrev`=0.
- **WAIT_LOAD:**
  - `shuffleFlag`=1.
  - On a detected rising edge: go to LOADING, clear `shuffleFlag`, clear the write index and seen-mask, and arm the phase counter.
- **LOADING:**
  - Capture `card` into `deck[wrIdx]` at edges k+1, k+1+P, k+1+2P, … , where k is the detect edge and P = LOAD_PERIOD.
  - `wrIdx` increments per capture.
  - If `card` ≥ DECK_SIZE, or its seen-mask bit is already set: set `loadErr`, but store the card anyway.
  - After DECK_SIZE captures: go to READY, `cardsLeft`=DECK_SIZE, `rdIdx`=0, `deckReady`=1.
  - If `loadFlag` is sampled 0 in LOADING: abort to WAIT_LOAD, set `loadErr`, and discard the partial deck.
- **READY:**
  - `dealReq` → `dealCard`=`deck[rdIdx]`, `dealValid`=1 for one cycle, `rdIdx`+1, `cardsLeft`−1.
  - When `cardsLeft` reaches 0: go to EMPTY, `deckReady`=0, `deckEmpty`=1.
- **EMPTY:** `dealReq` is ignored, and `dealValid` stays 0.
- **`newDeck`:**
  - In READY/EMPTY: go to WAIT_LOAD, clear `deckReady`, `deckEmpty`, `cardsLeft` and `loadErr`; `shuffleFlag`=1 on the next edge.
  - Ignored in WAIT_LOAD/LOADING.
- `dealReq` is ignored in WAIT_LOAD and LOADING.
- `dealReq` and `newDeck` in the same cycle: `newDeck` wins, no deal.
- `loadFlag` already high when WAIT_LOAD is entered (shuffler not reset): no rising edge is seen, so the block waits until `loadFlag` drops and rises again.

## Timing
- **Reset values:**
  - State WAIT_LOAD.
  - `shuffleFlag`=0; it rises on the first edge after `rst` deasserts.
  - `dealValid`=0, `dealCard`=0, `cardsLeft`=0, `deckReady`=0, `deckEmpty`=0, `loadErr`=0, `loadPrev`=0.
- Reset mid-load or mid-deal: immediate clear to the values above; buffer contents are don't-care.
- **Load cadence:**
  - With P=2, the shuffler raises `loadFlag` at edge E1 and updates `card` at E2, E4, … , E104.
  - The receiver detects at E2 and captures at E3, E5, … , E105.
  - `deckReady`=1 after E105.
- **Deal latency:** `dealReq` sampled at edge n → `dealValid`/`dealCard`/`cardsLeft` updated at edge n; `dealValid` clears at n+1 unless `dealReq` is high again.
- Back-to-back `dealReq` every cycle is supported: one card per cycle.
- `dealCard` holds its last value when `dealValid`=0.
- The last deal and `deckEmpty` assert on the same edge.

## Test plan
- **Reset/request:** release `rst` → `shuffleFlag`=1 after one edge; all other outputs 0.
- **Normal load:**
  - Stimulus: raise `loadFlag`, then stream cards 51, 50, … , 0 on a P=2 cadence.
  - Required: `deckReady`=1 after capture 52, `cardsLeft`=52, `loadErr`=0.
  - 52 consecutive `dealReq` return 51…0 in order; `deckEmpty`=1 with the last deal; a 53rd `dealReq` → no `dealValid`.
- **Error detect:**
  - Stream with card 7 repeated at positions 3 and 9 → `loadErr`=1 after position 9.
  - Stream with value 60 → `loadErr`=1.
  - In both cases, `deckReady` still asserts after 52 captures.
- **Abort:** drop `loadFlag` after 20 captures → state WAIT_LOAD, `loadErr`=1, `shuffleFlag`=1, `deckReady`=0.
- **Collision/new deck:**
  - `dealReq`+`newDeck` in the same READY cycle → no `dealValid`; `shuffleFlag`=1 next edge; `cardsLeft`=0.
  - A second full load then succeeds.
- **Async reset mid-deal:** assert `rst` with `cardsLeft`=30 → all outputs at reset values immediately, without waiting for a clock edge.
